// File: rtl/stack_mem_unit_if.sv
// Request/response bundle between the decode-stage controller (master)
// and the memory-stage stack unit (slave).
interface stack_mem_unit_if #(
   parameter int unsigned ADDR_W = 11
);
   logic              mem_read;
   logic              mem_write;
   logic              mem_push;
   logic              mem_pop;
   logic [1:0]        mem_addsel;
   logic [1:0]        mem_src_select;
   logic              pop_to_pc;
   logic              flag_reg_select;
   logic [15:0]       alu_addr;
   logic [15:0]       src_addr;
   logic [15:0]       reg_data;
   logic [31:0]       pc_in;
   logic [2:0]        flags_in;

   logic [15:0]       read_data;
   logic              read_valid;
   logic [31:0]       pc_out;
   logic              pc_valid;
   logic [2:0]        flags_out;
   logic              flags_valid;
   logic [ADDR_W-1:0] sp;
   logic              stack_overflow;
   logic              stack_underflow;
   logic              protocol_err;

   modport master (
      output mem_read, mem_write, mem_push, mem_pop, mem_addsel, mem_src_select,
             pop_to_pc, flag_reg_select, alu_addr, src_addr, reg_data, pc_in, flags_in,
      input  read_data, read_valid, pc_out, pc_valid, flags_out, flags_valid, sp,
             stack_overflow, stack_underflow, protocol_err
   );

   modport slave (
      input  mem_read, mem_write, mem_push, mem_pop, mem_addsel, mem_src_select,
             pop_to_pc, flag_reg_select, alu_addr, src_addr, reg_data, pc_in, flags_in,
      output read_data, read_valid, pc_out, pc_valid, flags_out, flags_valid, sp,
             stack_overflow, stack_underflow, protocol_err
   );
endinterface

// File: rtl/stack_mem_unit.sv
// Memory-stage stack/data-memory responder with PC reassembly from popped halves.
// Optional build macro STACK_GUARD_EN enables overflow/underflow suppression.
module stack_mem_unit #(
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned SP_INIT     = (1 << ADDR_W) - 1,
   parameter int unsigned STACK_LIMIT = 1 << (ADDR_W - 1)
) (
   input logic              clk,
   input logic              reset,
   stack_mem_unit_if.slave  bus
);

   localparam int unsigned       DEPTH  = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] SP_RST = SP_INIT[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] SP_LIM = STACK_LIMIT[ADDR_W-1:0];

   typedef enum logic {PC_IDLE, PC_HALF} pc_state_t;
   typedef enum logic [1:0] {DST_REG, DST_FLAG, DST_PC_LO, DST_PC_HI} dest_t;

   logic [15:0]       mem [DEPTH];
   logic [15:0]       mem_q;
   logic [ADDR_W-1:0] sp_q;
   logic [ADDR_W-1:0] acc_addr;
   logic [15:0]       wr_data;

   logic any_req, illegal, legal;
   logic push_req, pop_req, store_req, load_req;
   logic push_ok, pop_ok, do_write, do_read;
   logic flag_pop, pc_pop, pc_abort;

   pc_state_t pc_state, pc_next;
   dest_t     rd_dest_d, rd_dest;
   logic      rd_pend;
   logic      proto_err_q;

   logic [15:0] read_data_q;
   logic        read_valid_q;
   logic [15:0] pc_lo_q;
   logic [31:0] pc_out_q;
   logic        pc_valid_q;
   logic [2:0]  flags_out_q;
   logic        flags_valid_q;

   assign any_req   = bus.mem_read | bus.mem_write;
   assign illegal   = (bus.mem_read & bus.mem_write) | (bus.mem_push & bus.mem_pop) |
                      (any_req & (bus.mem_addsel == 2'b11));
   assign legal     = any_req & ~illegal;
   assign push_req  = legal & bus.mem_write & bus.mem_push;
   assign pop_req   = legal & bus.mem_read & bus.mem_pop;
   assign store_req = legal & bus.mem_write & ~bus.mem_push;
   assign load_req  = legal & bus.mem_read & ~bus.mem_pop;

`ifdef STACK_GUARD_EN
   logic ovf_q, unf_q;

   assign push_ok = push_req & (sp_q >= SP_LIM);
   assign pop_ok  = pop_req & (sp_q != SP_RST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (push_req && !push_ok) ovf_q <= 1'b1;
         if (pop_req && !pop_ok)   unf_q <= 1'b1;
      end
   end

   assign bus.stack_overflow  = ovf_q;
   assign bus.stack_underflow = unf_q;
`else
   logic unused_cfg;

   assign push_ok             = push_req;
   assign pop_ok              = pop_req;
   assign unused_cfg          = ^SP_LIM;
   assign bus.stack_overflow  = 1'b0;
   assign bus.stack_underflow = 1'b0;
`endif

   assign do_write = store_req | push_ok;
   assign do_read  = load_req | pop_ok;
   assign flag_pop = pop_ok & bus.flag_reg_select;
   assign pc_pop   = pop_ok & bus.pop_to_pc & ~bus.flag_reg_select;
   // Abort is judged on the request, so a guard-suppressed push still breaks the pair.
   assign pc_abort = (pc_state == PC_HALF) &
                     (push_req | (pop_req & bus.flag_reg_select) | (pop_req & ~bus.pop_to_pc));

   always_comb begin
      wr_data = bus.reg_data;
      unique case (bus.mem_src_select)
         2'b00: wr_data = {13'b0, bus.flags_in};
         2'b01: wr_data = bus.pc_in[31:16];
         2'b10: wr_data = bus.pc_in[15:0];
         2'b11: wr_data = bus.reg_data;
      endcase
   end

   always_comb begin
      acc_addr = '0;
      case (bus.mem_addsel)
         2'b00:   acc_addr = bus.alu_addr[ADDR_W-1:0];
         2'b01:   acc_addr = bus.src_addr[ADDR_W-1:0];
         2'b10:   acc_addr = bus.mem_read ? sp_q + ADDR_W'(1) : sp_q;
         default: acc_addr = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc_state <= PC_IDLE;
      else        pc_state <= pc_next;
   end

   always_comb begin
      pc_next = pc_state;
      unique case (pc_state)
         PC_IDLE: if (pc_pop) pc_next = PC_HALF;
         PC_HALF: if (pc_pop || pc_abort) pc_next = PC_IDLE;
      endcase
   end

   always_comb begin
      rd_dest_d = DST_REG;
      if (flag_pop)    rd_dest_d = DST_FLAG;
      else if (pc_pop) rd_dest_d = (pc_state == PC_IDLE) ? DST_PC_LO : DST_PC_HI;
   end

   // Array and read register carry no reset so the store maps onto block RAM.
   always_ff @(posedge clk) begin
      if (do_write) mem[acc_addr] <= wr_data;
      if (do_read)  mem_q <= mem[acc_addr];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp_q        <= SP_RST;
         rd_pend     <= 1'b0;
         rd_dest     <= DST_REG;
         proto_err_q <= 1'b0;
      end else begin
         rd_pend     <= do_read;
         rd_dest     <= rd_dest_d;
         proto_err_q <= illegal | pc_abort;
         if (push_ok)     sp_q <= sp_q - ADDR_W'(1);
         else if (pop_ok) sp_q <= sp_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_data_q   <= '0;
         read_valid_q  <= 1'b0;
         pc_lo_q       <= '0;
         pc_out_q      <= '0;
         pc_valid_q    <= 1'b0;
         flags_out_q   <= '0;
         flags_valid_q <= 1'b0;
      end else begin
         read_valid_q  <= rd_pend && (rd_dest == DST_REG);
         flags_valid_q <= rd_pend && (rd_dest == DST_FLAG);
         pc_valid_q    <= rd_pend && (rd_dest == DST_PC_HI);
         if (rd_pend) begin
            case (rd_dest)
               DST_REG:   read_data_q <= mem_q;
               DST_FLAG:  flags_out_q <= mem_q[2:0];
               DST_PC_LO: pc_lo_q     <= mem_q;
               DST_PC_HI: pc_out_q    <= {mem_q, pc_lo_q};
            endcase
         end
      end
   end

   logic unused_addr_hi;
   assign unused_addr_hi = ^{bus.alu_addr[15:ADDR_W], bus.src_addr[15:ADDR_W]};

   assign bus.sp           = sp_q;
   assign bus.read_data    = read_data_q;
   assign bus.read_valid   = read_valid_q;
   assign bus.pc_out       = pc_out_q;
   assign bus.pc_valid     = pc_valid_q;
   assign bus.flags_out    = flags_out_q;
   assign bus.flags_valid  = flags_valid_q;
   assign bus.protocol_err = proto_err_q;

endmodule

// File: tb/tb_stack_mem_unit.sv
// Scoreboard bench for stack_mem_unit: expected pulses are queued with their
// arrival cycle when a request is driven and matched against DUT outputs.
module tb_stack_mem_unit;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   stack_mem_unit_if #(.ADDR_W(11)) bus ();

   stack_mem_unit #(.ADDR_W(11)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int unsigned cyc;
      int          kind;   // 0 read, 1 flags, 2 pc, 3 protocol_err
      logic [31:0] data;
   } exp_t;
   exp_t sbq[$];

   task automatic expect_ev(input int kind, input logic [31:0] data, input int unsigned dly);
      exp_t e;
      e.cyc  = cyc + dly;
      e.kind = kind;
      e.data = data;
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin
      logic [3:0] obs;
      logic [3:0] seen;
      obs  = {bus.protocol_err, bus.pc_valid, bus.flags_valid, bus.read_valid};
      seen = '0;
      for (int i = int'(sbq.size()) - 1; i >= 0; i--) begin
         if (sbq[i].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL sb_missing kind %0d: got no pulse, need pulse at cycle %0d data %h",
                     sbq[i].kind, sbq[i].cyc, sbq[i].data);
            sbq.delete(i);
         end else if (sbq[i].cyc == cyc) begin
            checks++;
            seen[sbq[i].kind] = 1'b1;
            case (sbq[i].kind)
               0: if (obs[0] !== 1'b1 || bus.read_data !== sbq[i].data[15:0]) begin
                     errors++;
                     $display("FAIL sb_read: got valid %b data %h, need valid 1 data %h",
                              obs[0], bus.read_data, sbq[i].data[15:0]);
                  end
               1: if (obs[1] !== 1'b1 || bus.flags_out !== sbq[i].data[2:0]) begin
                     errors++;
                     $display("FAIL sb_flags: got valid %b flags %b, need valid 1 flags %b",
                              obs[1], bus.flags_out, sbq[i].data[2:0]);
                  end
               2: if (obs[2] !== 1'b1 || bus.pc_out !== sbq[i].data) begin
                     errors++;
                     $display("FAIL sb_pc: got valid %b pc %h, need valid 1 pc %h",
                              obs[2], bus.pc_out, sbq[i].data);
                  end
               default: if (obs[3] !== 1'b1) begin
                     errors++;
                     $display("FAIL sb_perr: got protocol_err %b, need 1", obs[3]);
                  end
            endcase
            sbq.delete(i);
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (obs[k] === 1'b1 && !seen[k]) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected kind %0d at cycle %0d: got pulse, need none", k, cyc);
         end
      end
   end

   task automatic drive_idle();
      bus.mem_read        = 1'b0;
      bus.mem_write       = 1'b0;
      bus.mem_push        = 1'b0;
      bus.mem_pop         = 1'b0;
      bus.mem_addsel      = 2'b00;
      bus.mem_src_select  = 2'b00;
      bus.pop_to_pc       = 1'b0;
      bus.flag_reg_select = 1'b0;
   endtask

   task automatic do_push(input logic [1:0] src, input logic [15:0] data);
      drive_idle();
      bus.mem_write      = 1'b1;
      bus.mem_push       = 1'b1;
      bus.mem_addsel     = 2'b10;
      bus.mem_src_select = src;
      bus.reg_data       = data;
      @(negedge clk);
      drive_idle();
   endtask

   task automatic do_pop(input bit to_pc, input bit to_flag);
      drive_idle();
      bus.mem_read        = 1'b1;
      bus.mem_pop         = 1'b1;
      bus.mem_addsel      = 2'b10;
      bus.pop_to_pc       = to_pc;
      bus.flag_reg_select = to_flag;
      @(negedge clk);
      drive_idle();
   endtask

   task automatic do_store(input logic [15:0] addr, input logic [15:0] data);
      drive_idle();
      bus.mem_write      = 1'b1;
      bus.mem_addsel     = 2'b00;
      bus.mem_src_select = 2'b11;
      bus.alu_addr       = addr;
      bus.reg_data       = data;
      @(negedge clk);
      drive_idle();
   endtask

   task automatic do_load(input logic [15:0] addr);
      drive_idle();
      bus.mem_read   = 1'b1;
      bus.mem_addsel = 2'b01;
      bus.src_addr   = addr;
      @(negedge clk);
      drive_idle();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      drive_idle();
      wait_cycles(2);
      reset = 1'b1;
   endtask

   task automatic check_sp(input string name, input logic [10:0] need);
      checks++;
      if (bus.sp !== need) begin
         errors++;
         $display("FAIL %s: got sp %0d, need %0d", name, bus.sp, need);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      check_sp("reset_sp", 11'd2047);
      checks++;
      if ({bus.read_data, bus.read_valid, bus.pc_out, bus.pc_valid, bus.flags_out,
           bus.flags_valid, bus.stack_overflow, bus.stack_underflow, bus.protocol_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rd %h rv %b pc %h pv %b fl %b fv %b ovf %b unf %b perr %b, need all 0",
                  bus.read_data, bus.read_valid, bus.pc_out, bus.pc_valid, bus.flags_out,
                  bus.flags_valid, bus.stack_overflow, bus.stack_underflow, bus.protocol_err);
      end
   endtask

   task automatic test_push_pop();
      do_push(2'b11, 16'hBEEF);
      check_sp("push_sp", 11'd2046);
      expect_ev(0, 32'h0000_BEEF, 2);
      do_pop(1'b0, 1'b0);
      check_sp("pop_sp", 11'd2047);
      wait_cycles(2);
   endtask

   task automatic test_call_ret();
      bus.pc_in = 32'h0001_2345;
      do_push(2'b01, 16'h0);
      do_push(2'b10, 16'h0);
      check_sp("call_sp", 11'd2045);
      do_pop(1'b1, 1'b0);
      expect_ev(2, 32'h0001_2345, 2);
      do_pop(1'b1, 1'b0);
      check_sp("ret_sp", 11'd2047);
      wait_cycles(3);
   endtask

   task automatic test_interrupt();
      bus.pc_in    = 32'hCAFE_0042;
      bus.flags_in = 3'b101;
      do_push(2'b01, 16'h0);
      do_push(2'b10, 16'h0);
      do_push(2'b00, 16'h0);
      check_sp("irq_frame_sp", 11'd2044);
      expect_ev(1, 32'h5, 2);
      do_pop(1'b0, 1'b1);
      do_pop(1'b1, 1'b0);
      expect_ev(2, 32'hCAFE_0042, 2);
      do_pop(1'b1, 1'b0);
      check_sp("reti_sp", 11'd2047);
      wait_cycles(3);
   endtask

   task automatic test_plain();
      do_store(16'h0010, 16'h0007);
      check_sp("store_sp", 11'd2047);
      expect_ev(0, 32'h7, 2);
      do_load(16'h0010);
      check_sp("load_sp", 11'd2047);
      wait_cycles(2);
   endtask

   task automatic test_back_to_back();
      do_push(2'b11, 16'h1234);
      expect_ev(0, 32'h1234, 2);
      do_pop(1'b0, 1'b0);
      do_push(2'b11, 16'h0A0A);
      do_push(2'b11, 16'h0B0B);
      expect_ev(0, 32'h0B0B, 2);
      do_pop(1'b0, 1'b0);
      expect_ev(0, 32'h0A0A, 2);
      do_pop(1'b0, 1'b0);
      check_sp("b2b_sp", 11'd2047);
      wait_cycles(3);
   endtask

   task automatic test_illegal();
      drive_idle();
      bus.mem_read       = 1'b1;
      bus.mem_write      = 1'b1;
      bus.mem_src_select = 2'b11;
      bus.alu_addr       = 16'h0010;
      bus.reg_data       = 16'hFFFF;
      expect_ev(3, 32'h0, 1);
      @(negedge clk);
      drive_idle();
      expect_ev(0, 32'h7, 2);
      do_load(16'h0010);
      bus.mem_write      = 1'b1;
      bus.mem_addsel     = 2'b11;
      bus.mem_src_select = 2'b11;
      expect_ev(3, 32'h0, 1);
      @(negedge clk);
      drive_idle();
      bus.mem_write  = 1'b1;
      bus.mem_push   = 1'b1;
      bus.mem_pop    = 1'b1;
      bus.mem_addsel = 2'b10;
      expect_ev(3, 32'h0, 1);
      @(negedge clk);
      drive_idle();
      check_sp("illegal_sp", 11'd2047);
      wait_cycles(3);
   endtask

   task automatic test_pc_abort();
      bus.pc_in = 32'h1357_2468;
      do_push(2'b01, 16'h0);
      do_push(2'b10, 16'h0);
      do_pop(1'b1, 1'b0);
      expect_ev(3, 32'h0, 1);
      do_push(2'b11, 16'h5555);
      check_sp("abort_sp", 11'd2045);
      expect_ev(0, 32'h5555, 2);
      do_pop(1'b0, 1'b0);
      expect_ev(0, 32'h1357, 2);
      do_pop(1'b0, 1'b0);
      check_sp("abort_clean_sp", 11'd2047);
      wait_cycles(3);
   endtask

   task automatic test_stack_limits();
`ifdef STACK_GUARD_EN
      do_pop(1'b0, 1'b0);
      check_sp("underflow_sp", 11'd2047);
      checks++;
      if (bus.stack_underflow !== 1'b1 || bus.stack_overflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow_flag: got unf %b ovf %b, need unf 1 ovf 0",
                  bus.stack_underflow, bus.stack_overflow);
      end
      wait_cycles(2);
      for (int i = 0; i < 1024; i++) do_push(2'b11, 16'(i));
      check_sp("fill_sp", 11'd1023);
      checks++;
      if (bus.stack_overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_early: got %b, need 0", bus.stack_overflow);
      end
      do_push(2'b11, 16'hDEAD);
      check_sp("overflow_sp", 11'd1023);
      checks++;
      if (bus.stack_overflow !== 1'b1 || bus.stack_underflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_flag: got ovf %b unf %b, need ovf 1 unf 1",
                  bus.stack_overflow, bus.stack_underflow);
      end
      apply_reset();
      check_sp("guard_reset_sp", 11'd2047);
`else
      do_store(16'h0000, 16'h00AA);
      expect_ev(0, 32'h00AA, 2);
      do_pop(1'b0, 1'b0);
      check_sp("wrap_pop_sp", 11'd0);
      do_push(2'b11, 16'h0101);
      check_sp("wrap_push_sp", 11'd2047);
      checks++;
      if (bus.stack_overflow !== 1'b0 || bus.stack_underflow !== 1'b0) begin
         errors++;
         $display("FAIL fault_tied: got ovf %b unf %b, need 0 0",
                  bus.stack_overflow, bus.stack_underflow);
      end
      wait_cycles(2);
`endif
   endtask

   task automatic test_reset_mid_pc();
      bus.pc_in = 32'h2468_ACE0;
      do_push(2'b01, 16'h0);
      do_push(2'b10, 16'h0);
      do_pop(1'b1, 1'b0);
      reset = 1'b0;
      wait_cycles(2);
      reset = 1'b1;
      check_sp("mid_reset_sp", 11'd2047);
      checks++;
      if ({bus.read_data, bus.read_valid, bus.pc_out, bus.pc_valid, bus.flags_out,
           bus.flags_valid, bus.stack_overflow, bus.stack_underflow, bus.protocol_err} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got rd %h pc %h fl %b valids %b%b%b perr %b, need all 0",
                  bus.read_data, bus.pc_out, bus.flags_out, bus.read_valid, bus.pc_valid,
                  bus.flags_valid, bus.protocol_err);
      end
      wait_cycles(3);
      bus.pc_in = 32'h0F0F_F0F0;
      do_push(2'b01, 16'h0);
      do_push(2'b10, 16'h0);
      do_pop(1'b1, 1'b0);
      expect_ev(2, 32'h0F0F_F0F0, 2);
      do_pop(1'b1, 1'b0);
      check_sp("post_reset_ret_sp", 11'd2047);
      wait_cycles(3);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: got no completion, need finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset        = 1'b1;
      bus.alu_addr = '0;
      bus.src_addr = '0;
      bus.reg_data = '0;
      bus.pc_in    = '0;
      bus.flags_in = '0;
      drive_idle();
      #2 reset = 1'b0;
      test_reset();
      test_push_pop();
      test_call_ret();
      test_interrupt();
      test_plain();
      test_back_to_back();
      test_illegal();
      test_pc_abort();
      test_stack_limits();
      test_reset_mid_pc();
      wait_cycles(3);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending entries, need 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
